pulse_shaper: RTL

Polyphase interpolating FIR that consumes the symbol-rate I/Q stream (one `den` pulse per symbol) from the upstream symbol/level generator. It produces band-limited I/Q samples at the DAC sample rate, one output per `ostb` strobe. A single time-multiplexed multiply-accumulate (MAC) is used per rail. It sits between the symbol generator and the DAC/upconversion path.

---
 rtl/pulse_shaper_pkg.sv | 49 ++++
 rtl/pulse_shaper_mac_rail.sv | 58 +++++
 rtl/pulse_shaper.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pulse_shaper_pkg.sv
// pulse_shaper_pkg
// Shared constants, types and helpers for the polyphase interpolating
// pulse shaper: filter geometry, accumulator width, FSM state type, the
// RRC coefficient ROM and the round/saturate helper used by each rail.
// Retuning OSR/NT means regenerating COEF, which is laid out for them.
package pulse_shaper_pkg;

  localparam int OSR   = 4;                 // output samples per symbol
  localparam int NT    = 8;                 // taps per phase
  localparam int CW    = 16;                // coefficient width, Q1.15
  localparam int DW    = 16;                // sample / symbol width
  localparam int PW    = DW + CW;           // product width
  localparam int ACC_W = PW + $clog2(NT);   // accumulator width
  localparam int K_W   = $clog2(NT);
  // One extra bit so "all phases used" (ph == OSR) is representable.
  localparam int PH_W  = $clog2(OSR) + 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  // Root-raised-cosine, roll-off 0.35, 8-symbol span, peak ~0.79.
  // h[n] sits at t = (n - 16) / OSR symbols; indexed as h[k*OSR + ph].
  localparam logic signed [CW-1:0] COEF [OSR*NT] = '{
    16'sd49,     16'sd317,    16'sd226,    -16'sd226,
    -16'sd603,   -16'sd351,   16'sd608,    16'sd1550,
    16'sd1355,   -16'sd523,   -16'sd3208,  -16'sd4477,
    -16'sd2010,  16'sd4911,   16'sd14425,  16'sd22714,
    16'sd26000,  16'sd22714,  16'sd14425,  16'sd4911,
    -16'sd2010,  -16'sd4477,  -16'sd3208,  -16'sd523,
    16'sd1355,   16'sd1550,   16'sd608,    -16'sd351,
    -16'sd603,   -16'sd226,   16'sd226,    16'sd317
  };

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (CW - 2);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) << (DW - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX - ACC_W'(1);

  // Q1.15 scaling back to sample units: round half up, then clamp.
  function automatic logic signed [DW-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND_HALF) >>> (CW - 1);
    if (r > SAT_MAX)
      return SAT_MAX[DW-1:0];
    else if (r < SAT_MIN)
      return SAT_MIN[DW-1:0];
    else
      return r[DW-1:0];
  endfunction

endpackage

// File: rtl/pulse_shaper_mac_rail.sv
// fir_mac_rail
// One rail (I or Q) of the pulse shaper: symbol delay line, serial MAC
// accumulator and the registered, rounded/saturated output sample.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     shift din into d[0] (d[0] is the newest symbol)
//   acc_clr       clear the accumulator before a MAC sequence
//   mac_en, k     accumulate d[k] * coef this cycle
//   mac_last      final tap: register round_sat(acc + last product)
//   coef          coefficient for tap k at the current phase
//   dout          filtered sample, held until the next mac_last
module fir_mac_rail
  import pulse_shaper_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic signed [DW-1:0] din,
  input  logic                 acc_clr,
  input  logic                 mac_en,
  input  logic                 mac_last,
  input  logic [K_W-1:0]       k,
  input  logic signed [CW-1:0] coef,
  output logic signed [DW-1:0] dout
);

  logic signed [DW-1:0]    d [NT];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [PW-1:0]    prod;

  always_comb begin
    prod    = d[k] * coef;
    acc_nxt = acc + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NT; j++) d[j] <= '0;
      acc  <= '0;
      dout <= '0;
    end else begin
      if (push) begin
        d[0] <= din;
        for (int j = 1; j < NT; j++) d[j] <= d[j-1];
      end
      if (acc_clr)
        acc <= '0;
      else if (mac_en)
        acc <= acc_nxt;
      // The last product is folded in combinationally so the sample is
      // ready in the DONE cycle rather than one cycle later.
      if (mac_last)
        dout <= round_sat(acc_nxt);
    end
  end

endmodule

// File: rtl/pulse_shaper.sv
// pulse_shaper
// Polyphase interpolating FIR between the symbol generator and the DAC
// path. One den per symbol in, one filtered I/Q sample per ostb out,
// using one serial MAC per rail (NT cycles per output).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   den, i_in, q_in    symbol strobe and signed symbol levels
//   ostb               output-sample request
//   i_out, q_out       filtered samples, updated when o_valid pulses
//   o_valid            one-cycle output strobe
//   busy               MAC sequence in progress
//   ovf                sticky overrun (dropped ostb or overwritten symbol)
//
// state | meaning
// IDLE  | apply pending/new symbol or zero-stuff, start MAC on ostb
// MAC   | one tap per cycle on both rails, k = 0..NT-1
// DONE  | o_valid/sample visible; back to IDLE next cycle
module pulse_shaper
  import pulse_shaper_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 den,
  input  logic signed [DW-1:0] i_in,
  input  logic signed [DW-1:0] q_in,
  input  logic                 ostb,
  output logic signed [DW-1:0] i_out,
  output logic signed [DW-1:0] q_out,
  output logic                 o_valid,
  output logic                 busy,
  output logic                 ovf
);

  state_t               state;
  logic [K_W-1:0]       k;
  logic [PH_W-1:0]      ph;
  logic                 pend_v;
  logic signed [DW-1:0] pend_i;
  logic signed [DW-1:0] pend_q;

  logic                 idle, push_pend, push_den, push_zero, push;
  logic                 start, mac_en, mac_last;
  logic signed [DW-1:0] push_i, push_q;
  logic signed [CW-1:0] coef;

  always_comb begin
    idle      = (state == IDLE);
    push_pend = idle && pend_v;
    push_den  = idle && den && !pend_v;
    // All phases of d[0] consumed and nothing new: flush with a zero.
    push_zero = idle && ostb && !pend_v && !den && (ph == PH_W'(OSR));
    push      = push_pend || push_den || push_zero;
    push_i    = '0;
    push_q    = '0;
    if (push_pend) begin
      push_i = pend_i;
      push_q = pend_q;
    end else if (push_den) begin
      push_i = i_in;
      push_q = q_in;
    end
    start    = idle && ostb;
    mac_en   = (state == MAC);
    mac_last = mac_en && (k == K_W'(NT - 1));
    // OSR is a power of two, so k*OSR + ph is a plain concatenation.
    coef     = COEF[{k, ph[PH_W-2:0]}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      ph      <= '0;
      pend_v  <= 1'b0;
      pend_i  <= '0;
      pend_q  <= '0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          // The pending symbol takes this cycle's push; a den arriving in
          // the same cycle waits in the freed pending slot.
          if (pend_v) begin
            pend_v <= den;
            if (den) begin
              pend_i <= i_in;
              pend_q <= q_in;
            end
          end
          if (push) ph <= '0;
          if (ostb) begin
            k     <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          if (k == K_W'(NT - 1)) begin
            busy    <= 1'b0;
            o_valid <= 1'b1;
            ph      <= ph + 1'b1;
            state   <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Outside IDLE symbols are parked and requests are overruns; DONE
      // counts too, since an ostb there breaks the minimum spacing.
      if (state != IDLE) begin
        if (den) begin
          pend_v <= 1'b1;
          pend_i <= i_in;
          pend_q <= q_in;
          if (pend_v) ovf <= 1'b1;
        end
        if (ostb) ovf <= 1'b1;
      end
    end
  end

  fir_mac_rail u_rail_i (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (push_i),
    .acc_clr  (start),
    .mac_en   (mac_en),
    .mac_last (mac_last),
    .k        (k),
    .coef     (coef),
    .dout     (i_out)
  );

  fir_mac_rail u_rail_q (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (push_q),
    .acc_clr  (start),
    .mac_en   (mac_en),
    .mac_last (mac_last),
    .k        (k),
    .coef     (coef),
    .dout     (q_out)
  );

endmodule
